// File: rtl/shift_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: FSM state
// encodings, the default word width and the bit-counter width helper.
package shift_pkg;

    // COLLECT: accepting serial bits. HOLD: a finished word waits in sr
    // because the output buffer is still occupied.
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int unsigned N_DEFAULT = 32'd4;

    // Counter width is ceil(log2(width)); kept at least one bit wide so the
    // counter vector is always legal.
    function automatic int unsigned cnt_width(input int unsigned width);
        if (width < 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(width);
        end
    endfunction

    localparam int unsigned CNT_W_DEFAULT = cnt_width(N_DEFAULT);

endpackage

// File: rtl/deser_out_buf.sv
// One-entry output buffer with valid/ready handshake. A load always wins
// over a drain in the same cycle, so a word handed over while the previous
// one leaves keeps o_valid high without a bubble.
module deser_out_buf
    import shift_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [n-1:0] i_data,
    input  logic         i_ready,
    output logic [n-1:0] o_data,
    output logic         o_valid
);

    logic [n-1:0] r_data;
    logic         r_valid;

    // Buffer register: load a completed word, or clear valid once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= {n{1'b0}};
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer. Bits are shifted into sr under a
// valid/ready handshake; a finished word moves to a one-entry output buffer,
// or waits in sr (HOLD) while the buffer is still occupied, back-pressuring
// the serial side until the consumer drains the buffer.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_valid,
    output logic         sin_ready,
    input  logic         msb_first,
    input  logic         frame_clr,
    output logic [n-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int unsigned    CW       = cnt_width(n);
    localparam logic [CW-1:0]  CNT_LAST = CW'(n - 1);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t        r_state;
    logic [n-1:0]  r_sr;
    logic [CW-1:0] r_cnt;
    logic          r_dir;

    logic          w_accept;
    logic          w_first;
    logic          w_dir_eff;
    logic [n-1:0]  w_sr_shift;
    logic          w_complete;
    logic          w_drain;
    logic          w_load;
    logic [n-1:0]  w_load_data;
    logic          w_out_valid;

    // Handshake decode, next shift value and buffer-load decision.
    always_comb begin
        w_accept    = sin_valid && (r_state == COLLECT);
        w_first     = (r_cnt == CNT_ZERO);
        // The direction is sampled on the first bit and frozen for the word.
        w_dir_eff   = w_first ? msb_first : r_dir;
        w_sr_shift  = w_dir_eff ? {r_sr[n-2:0], sin} : {sin, r_sr[n-1:1]};
        w_complete  = w_accept && (r_cnt == CNT_LAST);
        w_drain     = w_out_valid && out_ready;
        w_load      = 1'b0;
        w_load_data = r_sr;
        if (frame_clr) begin
            // Abort never feeds the buffer; a held word is thrown away.
            w_load = 1'b0;
        end else if (r_state == HOLD) begin
            w_load      = w_drain;
            w_load_data = r_sr;
        end else if (w_complete) begin
            w_load      = !w_out_valid || w_drain;
            w_load_data = w_sr_shift;
        end else begin
            w_load = 1'b0;
        end
    end

    // Collection FSM with shift register, bit counter and direction latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COLLECT;
            r_sr    <= {n{1'b0}};
            r_cnt   <= CNT_ZERO;
            r_dir   <= 1'b1;
        end else if (frame_clr) begin
            r_state <= COLLECT;
            r_sr    <= {n{1'b0}};
            r_cnt   <= CNT_ZERO;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        if (w_first) begin
                            r_dir <= msb_first;
                        end
                        if (w_complete) begin
                            r_cnt <= CNT_ZERO;
                            if (w_load) begin
                                r_sr <= {n{1'b0}};
                            end else begin
                                // Buffer busy: park the finished word in sr.
                                r_sr    <= w_sr_shift;
                                r_state <= HOLD;
                            end
                        end else begin
                            r_sr  <= w_sr_shift;
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (w_drain) begin
                        r_sr    <= {n{1'b0}};
                        r_state <= COLLECT;
                    end
                end
                default: begin
                    r_state <= COLLECT;
                    r_sr    <= {n{1'b0}};
                    r_cnt   <= CNT_ZERO;
                end
            endcase
        end
    end

    deser_out_buf #(
        .n(n)
    ) u_out_buf (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_data (w_load_data),
        .i_ready(out_ready),
        .o_data (out),
        .o_valid(w_out_valid)
    );

    assign out_valid = w_out_valid;
    assign sin_ready = (r_state == COLLECT);
    assign busy      = (r_cnt != CNT_ZERO) || (r_state == HOLD);

endmodule
